alu_wide_sequencer: RTL and testbench



---
 rtl/alu_wide_sequencer.sv | 108 ++++++++++
 tb/tb_alu_wide_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: issues a wide operation to an 8-bit ALU byte by byte, chaining carry and collecting the result.
module alu_wide_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [2:0]            io_req_op,
    input  logic [8*NBYTES-1:0]   io_req_a,
    input  logic [8*NBYTES-1:0]   io_req_b,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [8*NBYTES-1:0]   io_resp_data,
    output logic                  io_resp_carry,
    output logic [7:0]            io_alu_A,
    output logic [7:0]            io_alu_B,
    output logic [3:0]            io_alu_ALU_Sel,
    input  logic [7:0]            io_alu_Out,
    input  logic                  io_alu_CarryOut
);
    localparam int W  = 8*NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd5;

    logic [1:0]    state_q;
    logic [IW-1:0] idx_q;
    logic          cin_q, eqacc_q, resp_carry_q;
    logic [2:0]    op_q;
    logic [W-1:0]  a_q, b_q, res_q, resp_data_q;
    logic [W-1:0]  res_d, data_d;
    logic [7:0]    a_byte, b_byte, byte_res;
    logic          exec, arith, legal, last, cin_d, eq_d;

    assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign legal  = op_q <= OP_EQ;
    assign exec   = (state_q == ST_EXEC) && legal;
    assign last   = idx_q == IW'(NBYTES-1);
    assign a_byte = a_q[8*idx_q +: 8];
    assign b_byte = b_q[8*idx_q +: 8];

    assign io_alu_A       = exec ? a_byte : 8'h00;
    assign io_alu_B       = !exec ? 8'h00 : (op_q == OP_SUB) ? ~b_byte : b_byte;
    assign io_alu_ALU_Sel = !exec ? 4'b0000 : arith ? 4'b0000 :
                            (op_q == OP_AND) ? 4'b1000 : (op_q == OP_OR) ? 4'b1001 : 4'b1010;

    // The ALU adds without carry-in, so fold cin in here; Out==FF with cin also carries.
    assign cin_d    = io_alu_CarryOut | ((&io_alu_Out) & cin_q);
    assign eq_d     = eqacc_q | (io_alu_Out != 8'h00);
    assign byte_res = !legal ? 8'h00 : arith ? io_alu_Out + {7'b0, cin_q} : io_alu_Out;

    always_comb begin
        res_d = res_q;
        if (op_q != OP_EQ) res_d[8*idx_q +: 8] = byte_res;
        data_d = !legal ? '0 : (op_q == OP_EQ) ? {{(W-1){1'b0}}, ~eq_d} : res_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cin_q        <= 1'b0;
            eqacc_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (io_req_valid) begin
                op_q    <= io_req_op;
                a_q     <= io_req_a;
                b_q     <= io_req_b;
                idx_q   <= '0;
                cin_q   <= io_req_op == OP_SUB;
                eqacc_q <= 1'b0;
                state_q <= ST_EXEC;
            end
        end else if (state_q == ST_EXEC) begin
            res_q   <= res_d;
            cin_q   <= cin_d;
            eqacc_q <= eq_d;
            idx_q   <= last ? '0 : idx_q + IW'(1);
            if (last) begin
                state_q      <= ST_RESP;
                resp_data_q  <= data_d;
                resp_carry_q <= arith & cin_d;
            end
        end else if (state_q == ST_RESP) begin
            if (io_resp_ready) state_q <= ST_IDLE;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    assign io_req_ready  = state_q == ST_IDLE;
    assign io_resp_valid = state_q == ST_RESP;
    assign io_resp_data  = resp_data_q;
    assign io_resp_carry = resp_carry_q;
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer: directed checks of the wide ALU sequencer against a behavioural 8-bit ALU.
module tb_alu_wide_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, resp_carry;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0, req_b = '0, resp_data;
    logic [7:0]  alu_A, alu_B, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_c;
    logic [8:0]  alu_r;
    int          nvec = 0, nerr = 0, lat;
    logic [31:0] held_d;
    logic        held_c;

    alu_wide_sequencer #(.NBYTES(4)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready), .io_req_op(req_op),
        .io_req_a(req_a), .io_req_b(req_b),
        .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
        .io_resp_data(resp_data), .io_resp_carry(resp_carry),
        .io_alu_A(alu_A), .io_alu_B(alu_B), .io_alu_ALU_Sel(alu_sel),
        .io_alu_Out(alu_out), .io_alu_CarryOut(alu_c)
    );

    always #5 clock = ~clock;

    always_comb begin
        alu_r = 9'h000;
        case (alu_sel)
            4'b0000: alu_r = {1'b0, alu_A} + {1'b0, alu_B};
            4'b1000: alu_r = {1'b0, alu_A & alu_B};
            4'b1001: alu_r = {1'b0, alu_A | alu_B};
            4'b1010: alu_r = {1'b0, alu_A ^ alu_B};
            default: alu_r = 9'h000;
        endcase
    end
    assign alu_out = alu_r[7:0];
    assign alu_c   = alu_r[8];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        while (!req_ready && n < 20) begin tick(); n++; end
        tick();
        lat = 1;
        req_valid = 1'b0; req_op = 3'd7; req_a = ~a; req_b = ~b;
    endtask

    task automatic get(input string tag, input logic [31:0] exp_d, input logic exp_c);
        while (!resp_valid && lat < 20) begin tick(); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_data"}, resp_data, exp_d);
        chk({tag, "_carry"}, {31'b0, resp_carry}, {31'b0, exp_c});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_data", resp_data, 32'h0);
        chk("rst_carry", {31'b0, resp_carry}, 32'd0);
        chk("rst_alu", {20'b0, alu_A, alu_B, alu_sel}, 32'h0);
        reset = 1'b0;
        tick();

        send(3'd0, 32'h0000_00FF, 32'h0000_0001);
        chk("add1_alu", {20'b0, alu_A, alu_B, alu_sel}, {20'b0, 8'hFF, 8'h01, 4'b0000});
        chk("add1_busy", {31'b0, req_ready}, 32'd0);
        get("add1", 32'h0000_0100, 1'b0);
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001); get("add2", 32'h0000_0000, 1'b1);
        send(3'd1, 32'h0000_0005, 32'h0000_0003);
        chk("sub1_alu", {20'b0, alu_A, alu_B, alu_sel}, {20'b0, 8'h05, 8'hFC, 4'b0000});
        get("sub1", 32'h0000_0002, 1'b1);
        send(3'd1, 32'h0000_0000, 32'h0000_0001); get("sub2", 32'hFFFF_FFFF, 1'b0);
        send(3'd5, 32'h1234_5678, 32'h1234_5678); get("eq1", 32'h0000_0001, 1'b0);
        send(3'd5, 32'h1234_5678, 32'h1234_5679); get("eq0", 32'h0000_0000, 1'b0);
        send(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000);
        chk("xor_alu", {20'b0, alu_A, alu_B, alu_sel}, {20'b0, 8'hF0, 8'h00, 4'b1010});
        get("xor", 32'h0F0F_F0F0, 1'b0);
        send(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00); get("and", 32'hF000_F000, 1'b0);
        send(3'd3, 32'h0F0F_0000, 32'h00F0_00F0); get("or", 32'h0FFF_00F0, 1'b0);

        send(3'd0, 32'h1111_1111, 32'h2222_2222);
        while (!resp_valid && lat < 20) begin tick(); lat++; end
        chk("bp_lat", 32'(lat), 32'd5);
        held_d = resp_data; held_c = resp_carry;
        chk("bp_data", held_d, 32'h3333_3333);
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'h0000_0002; req_b = 32'h0000_0003;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", resp_data, 32'h3333_3333);
            chk("bp_hold_carry", {31'b0, resp_carry}, {31'b0, held_c});
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'b0, resp_valid}, 32'd0);
        send(3'd0, 32'h0000_0002, 32'h0000_0003); get("bp_next", 32'h0000_0005, 1'b0);

        send(3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("ill_alu", {20'b0, alu_A, alu_B, alu_sel}, 32'h0);
        get("ill", 32'h0000_0000, 1'b0);

        send(3'd0, 32'h0101_0101, 32'h0101_0101);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_alu", {20'b0, alu_A, alu_B, alu_sel}, 32'h0);
        tick();
        chk("mid_rst_nodrop", {31'b0, resp_valid}, 32'd0);
        send(3'd0, 32'h0000_0001, 32'h0000_0001); get("post_rst", 32'h0000_0002, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
